mcu_gpio_cmd_if: RTL and testbench

//  Command front-end between the MCU GPIO pair (gpio_o_data_tri_o / gpio_i_data_tri_i) and the conv/memory core.

---
 rtl/mcu_gpio_cmd_if.sv | 221 ++++++++++++++++++++++
 tb/tb_mcu_gpio_cmd_if.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_gpio_cmd_if.sv
// MCU GPIO command front-end: synchronises strobes, drives writes/start/reads.
// Optional feature macro MCU_IF_LOOPBACK_EN: gpio[5] level makes RD return last write.
module mcu_gpio_cmd_if #(
   parameter int GPIO_D    = 32,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 10,
   parameter int KRN_DEPTH = 9,
   parameter int IMG_DEPTH = 1024
) (
   input  logic              i_CLK,
   input  logic              i_RST,
   input  logic [GPIO_D-1:0] i_gpio,
   output logic [GPIO_D-1:0] o_gpio,
   output logic              o_soft_rst,
   output logic              o_wr_valid,
   output logic              o_wr_sel,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   input  logic              i_wr_ready,
   output logic              o_start,
   input  logic              i_conv_done,
   input  logic              i_rd_valid,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_rd_ready,
   output logic              o_led
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam int PAD_W = GPIO_D - 5 - DATA_W;

   logic [GPIO_D-1:0] sync1_q;
   logic [GPIO_D-1:0] sync2_q;
   logic [4:0]        edge_q;
   logic [4:0]        stb_q;
   logic [DATA_W-1:0] pay_q;

   state_t            state_q;
   state_t            state_d;
   logic              ack_q;
   logic              udf_q;
   logic              err_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [ADDR_W-1:0] krn_addr_q;
   logic [ADDR_W-1:0] img_addr_q;
   logic [ADDR_W-1:0] krn_nxt;
   logic [ADDR_W-1:0] img_nxt;

   logic              wr_req;
   logic              wr_bad;
   logic              wr_go;
   logic              wr_done;
   logic              err_set;
   logic              do_start;
   logic              unused_bits;

   assign unused_bits = ^sync2_q[GPIO_D-DATA_W-1:5];

   // Strobe bits use a third stage for edge detect; the pulse is registered
   // once more so commands act three edges after the MCU level is sampled.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
         edge_q  <= '0;
         stb_q   <= '0;
         pay_q   <= '0;
      end else begin
         sync1_q <= i_gpio;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q[4:0];
         stb_q   <= sync2_q[4:0] & ~edge_q;
         pay_q   <= sync2_q[GPIO_D-1 -: DATA_W];
      end
   end

`ifdef MCU_IF_LOOPBACK_EN
   logic              lb_stb_q;
   logic [DATA_W-1:0] lb_q;

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         lb_stb_q <= 1'b0;
         lb_q     <= '0;
      end else begin
         lb_stb_q <= sync2_q[5];
         if (wr_done) begin
            lb_q <= o_wr_data;
         end
      end
   end
`endif

   assign wr_done = o_wr_valid & i_wr_ready;

   assign krn_nxt = (krn_addr_q == ADDR_W'(KRN_DEPTH - 1)) ?
                    '0 : krn_addr_q + ADDR_W'(1);
   assign img_nxt = (img_addr_q == ADDR_W'(IMG_DEPTH - 1)) ?
                    '0 : img_addr_q + ADDR_W'(1);

   always_comb begin
      wr_req   = stb_q[1] | stb_q[4];
      wr_bad   = wr_req & (o_wr_valid | (stb_q[1] & stb_q[4]) |
                           (state_q == ST_RUN));
      wr_go    = wr_req & ~wr_bad & ~stb_q[0];
      err_set  = 1'b0;
      do_start = 1'b0;
      state_d  = state_q;
      if (stb_q[0]) begin
         state_d = ST_IDLE;
      end else begin
         err_set = wr_bad;
         unique case (state_q)
            ST_IDLE: begin
               if (stb_q[3]) begin
                  state_d  = ST_RUN;
                  do_start = 1'b1;
               end
            end
            ST_RUN: begin
               if (stb_q[3]) begin
                  err_set = 1'b1;
               end
               if (i_conv_done) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (stb_q[3]) begin
                  state_d  = ST_RUN;
                  do_start = 1'b1;
               end else if (wr_go) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         o_start    <= 1'b0;
         o_soft_rst <= 1'b0;
         o_rd_ready <= 1'b0;
         o_wr_valid <= 1'b0;
         o_wr_sel   <= 1'b0;
         o_wr_addr  <= '0;
         o_wr_data  <= '0;
         krn_addr_q <= '0;
         img_addr_q <= '0;
         ack_q      <= 1'b0;
         udf_q      <= 1'b0;
         err_q      <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         o_start    <= do_start;
         o_soft_rst <= stb_q[0];
         o_rd_ready <= 1'b0;
         if (stb_q[0]) begin
            // Soft reset abandons any pending write; only ack survives.
            o_wr_valid <= 1'b0;
            krn_addr_q <= '0;
            img_addr_q <= '0;
            udf_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
         end else begin
            if (err_set) begin
               err_q <= 1'b1;
            end
            if (wr_done) begin
               o_wr_valid <= 1'b0;
               if (o_wr_sel) begin
                  krn_addr_q <= krn_nxt;
               end else begin
                  img_addr_q <= img_nxt;
               end
            end
            if (wr_go) begin
               o_wr_valid <= 1'b1;
               o_wr_sel   <= stb_q[1];
               o_wr_addr  <= stb_q[1] ? krn_addr_q : img_addr_q;
               o_wr_data  <= pay_q;
            end
            if (stb_q[2]) begin
               ack_q <= ~ack_q;
`ifdef MCU_IF_LOOPBACK_EN
               if (lb_stb_q) begin
                  rd_data_q <= lb_q;
                  udf_q     <= 1'b0;
               end else
`endif
               if (i_rd_valid) begin
                  o_rd_ready <= 1'b1;
                  rd_data_q  <= i_rd_data;
                  udf_q      <= 1'b0;
               end else begin
                  udf_q <= 1'b1;
               end
            end
         end
      end
   end

   assign o_led  = (state_q == ST_DONE);
   assign o_gpio = {ack_q, udf_q, err_q, state_q, {PAD_W{1'b0}}, rd_data_q};

endmodule

// File: tb/tb_mcu_gpio_cmd_if.sv
// Scoreboard bench for mcu_gpio_cmd_if: directed strobes, monitor-side checks.
// Loopback section is compiled only with MCU_IF_LOOPBACK_EN.
module tb_mcu_gpio_cmd_if;

   localparam int GPIO_D = 32;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 10;

   localparam logic [4:0] C_SOFT  = 5'b00001;
   localparam logic [4:0] C_WRK   = 5'b00010;
   localparam logic [4:0] C_RD    = 5'b00100;
   localparam logic [4:0] C_START = 5'b01000;
   localparam logic [4:0] C_WRI   = 5'b10000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [GPIO_D-1:0] gpio_in = '0;
   logic [GPIO_D-1:0] gpio_out;
   logic              soft_rst;
   logic              wr_valid;
   logic              wr_sel;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready = 1'b0;
   logic              start;
   logic              conv_done = 1'b0;
   logic              rd_valid = 1'b0;
   logic [DATA_W-1:0] rd_data = '0;
   logic              rd_ready;
   logic              led;

   always #5 clk = ~clk;

   mcu_gpio_cmd_if dut (
      .i_CLK       (clk),
      .i_RST       (rst_n),
      .i_gpio      (gpio_in),
      .o_gpio      (gpio_out),
      .o_soft_rst  (soft_rst),
      .o_wr_valid  (wr_valid),
      .o_wr_sel    (wr_sel),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .i_wr_ready  (wr_ready),
      .o_start     (start),
      .i_conv_done (conv_done),
      .i_rd_valid  (rd_valid),
      .i_rd_data   (rd_data),
      .o_rd_ready  (rd_ready),
      .o_led       (led)
   );

   typedef struct packed {
      logic              sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct packed {
      logic              udf;
      logic              pop;
      logic [DATA_W-1:0] data;
   } rd_t;

   wr_t         wr_q[$];
   rd_t         rd_q[$];
   logic [1:0]  st_q[$];
   logic [15:0] fifo[$];

   int n_cmp = 0;
   int n_bad = 0;
   int n_soft = 0;
   int n_start = 0;
   int n_ack = 0;
   int n_pop = 0;
   logic prev_ack = 1'b0;
   logic exp_ack = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: DUT event with no expected entry", name);
   endtask

   // Result FIFO model: pops on o_rd_ready, presents head to the DUT.
   initial begin
      forever begin
         @(negedge clk);
         if (rd_ready && fifo.size() > 0) begin
            void'(fifo.pop_front());
         end
         rd_valid = (fifo.size() > 0);
         rd_data  = (fifo.size() > 0) ? fifo[0] : 16'h0;
      end
   end

   // Monitor: pops expected responses whenever the DUT presents an event.
   initial begin
      wr_t        ew;
      rd_t        er;
      logic [1:0] es;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (soft_rst) n_soft++;
            if (rd_ready) n_pop++;
            if (start) begin
               n_start++;
               if (st_q.size() == 0) unexpected("start");
               else begin
                  es = st_q.pop_front();
                  chk("start_state", 32'(gpio_out[GPIO_D-4 -: 2]), 32'(es));
               end
            end
            if (wr_valid && wr_ready) begin
               if (wr_q.size() == 0) unexpected("write");
               else begin
                  ew = wr_q.pop_front();
                  chk("write", 32'({wr_sel, wr_addr, wr_data}), 32'(ew));
               end
            end
            if (gpio_out[GPIO_D-1] != prev_ack) begin
               n_ack++;
               if (rd_q.size() == 0) unexpected("read");
               else begin
                  er = rd_q.pop_front();
                  chk("read", 32'({gpio_out[GPIO_D-2], rd_ready,
                                   gpio_out[DATA_W-1:0]}), 32'(er));
               end
            end
            prev_ack = gpio_out[GPIO_D-1];
         end
      end
   end

   task automatic send(input logic [4:0] cmd, input logic [15:0] pay,
                       input logic lb);
      @(posedge clk); #1;
      gpio_in = {pay, 10'b0, lb, cmd};
      repeat (2) @(posedge clk);
      #1;
      gpio_in = {pay, 10'b0, lb, 5'b0};
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic pulse_done();
      @(posedge clk); #1;
      conv_done = 1'b1;
      @(posedge clk); #1;
      conv_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic udf, input logic pop, input logic [15:0] d,
                     input logic lb);
      rd_q.push_back({udf, pop, d});
      exp_ack = ~exp_ack;
      send(C_RD, 16'h0, lb);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] fd [3];
      fd[0] = 16'h0011;
      fd[1] = 16'h0022;
      fd[2] = 16'h0033;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_gpio", gpio_out, 32'h0);
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_wr_valid", 32'(wr_valid), 32'h0);
      chk("rst_start", 32'(start), 32'h0);
      chk("rst_soft", 32'(soft_rst), 32'h0);
      chk("rst_rd_ready", 32'(rd_ready), 32'h0);

      send(C_SOFT, 16'h0, 1'b0);
      chk("soft_cnt", n_soft, 1);

      wr_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wr_q.push_back({1'b1, 10'(i), 16'(i + 1)});
         send(C_WRK, 16'(i + 1), 1'b0);
      end
      wr_q.push_back({1'b1, 10'd0, 16'h0055});
      send(C_WRK, 16'h0055, 1'b0);
      chk("krn_drain", wr_q.size(), 0);

      wr_ready = 1'b0;
      wr_q.push_back({1'b0, 10'd0, 16'hABCD});
      send(C_WRI, 16'hABCD, 1'b0);
      chk("stall_valid", 32'(wr_valid), 32'h1);
      chk("stall_err0", 32'(gpio_out[GPIO_D-3]), 32'h0);
      send(C_WRI, 16'h1111, 1'b0);
      chk("stall_data", 32'(wr_data), 32'hABCD);
      chk("stall_err1", 32'(gpio_out[GPIO_D-3]), 32'h1);
      wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("stall_drain", wr_q.size(), 0);

      send(C_SOFT, 16'h0, 1'b0);
      chk("soft_err", 32'(gpio_out[GPIO_D-3]), 32'h0);
      st_q.push_back(2'b01);
      send(C_START, 16'h0, 1'b0);
      chk("start_cnt1", n_start, 1);
      pulse_done();
      chk("done_state", 32'(gpio_out[GPIO_D-4 -: 2]), 32'h2);
      chk("done_led", 32'(led), 32'h1);
      st_q.push_back(2'b01);
      send(C_START, 16'h0, 1'b0);
      chk("start_cnt2", n_start, 2);
      chk("run_led", 32'(led), 32'h0);
      send(C_START, 16'h0, 1'b0);
      chk("start_in_run", n_start, 2);
      chk("run_err", 32'(gpio_out[GPIO_D-3]), 32'h1);
      send(C_WRI, 16'h7777, 1'b0);
      pulse_done();
      wr_q.push_back({1'b0, 10'd0, 16'h4242});
      send(C_WRI, 16'h4242, 1'b0);
      chk("done_wr_idle", 32'(gpio_out[GPIO_D-4 -: 2]), 32'h0);

      for (int i = 0; i < 3; i++) fifo.push_back(fd[i]);
      for (int i = 0; i < 3; i++) rd(1'b0, 1'b1, fd[i], 1'b0);
      rd(1'b1, 1'b0, 16'h0033, 1'b0);
      chk("ack_cnt", n_ack, 4);
      chk("pop_cnt", n_pop, 3);
      chk("ack_bit", 32'(gpio_out[GPIO_D-1]), 32'(exp_ack));

`ifdef MCU_IF_LOOPBACK_EN
      wr_q.push_back({1'b0, 10'd1, 16'h1234});
      send(C_WRI, 16'h1234, 1'b0);
      fifo.push_back(16'h9999);
      rd(1'b0, 1'b0, 16'h1234, 1'b1);
      chk("lb_nopop", fifo.size(), 1);
      chk("lb_pop_cnt", n_pop, 3);
`endif

      send(C_SOFT, 16'h0, 1'b0);
      chk("soft_gpio", gpio_out, {exp_ack, 31'b0});
      chk("end_wr_q", wr_q.size(), 0);
      chk("end_rd_q", rd_q.size(), 0);
      chk("end_st_q", st_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
